rr_encoder_4_2: RTL and testbench
=================================

RR_ENCODER_4_2 -- requirements
Module: rr_encoder_4_2

Interface
REQ-001 The module SHALL have no parameters; width is fixed at 4 request lines to a 2-bit index.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  4  request vector; bit i = requester i active; any number of bits may be set.
REQ-005 out_ready  input  1  consumer accepts the current output this cycle.
REQ-006 out_valid  output  1  registered; out_idx/out_multi hold a captured, unaccepted result.
REQ-007 out_idx  output  2  registered binary index of the selected requester.
REQ-008 out_multi  output  1  registered; more than one req bit was set at capture.
REQ-009 out_onehot  output  4  combinational: 4'b0001 << out_idx when out_valid=1, else 4'b0000.

Function
REQ-010 State SHALL be out_valid, out_idx, out_multi and a 2-bit priority pointer ptr; there is no other state.
REQ-011 States: EMPTY (out_valid=0) and HOLD (out_valid=1).
REQ-012 Capture window: open when out_valid=0, or when out_valid=1 and out_ready=1.
REQ-013 In the capture window, if req!=0 the block SHALL register the first set bit searched circularly from pointer p: p, p+1, p+2, p+3 mod 4. It SHALL then set out_valid=1 and set out_multi=(popcount(req)>1).
REQ-014 In the capture window with req==0: out_valid<=0. out_idx and out_multi SHALL hold their previous values.
REQ-015 Search pointer p = ptr when no accept occurs this cycle; p = out_idx+1 (mod 4, 3 wraps to 0) when out_valid&&out_ready this cycle.
REQ-016 On every accept (out_valid&&out_ready), ptr <= out_idx+1 mod 4; ptr SHALL NOT change otherwise.
REQ-017 In HOLD with out_ready=0: out_valid, out_idx, out_multi and ptr SHALL remain stable; req changes are ignored.
REQ-018 Latency: req sampled at edge N is visible on out_idx/out_valid after edge N; 1 cycle, no bubbles.
REQ-019 Simultaneous accept and nonzero req SHALL give back-to-back valid results, one per cycle.
REQ-020 out_ready while out_valid=0 SHALL have no effect.
REQ-021 No combinational path SHALL exist from req or out_ready to out_valid, out_idx or out_multi.

Reset
REQ-022 While reset=1: out_valid=0, out_idx=2'b00, out_multi=0, ptr=2'b00, out_onehot=4'b0000, immediately and regardless of clock.
REQ-023 Reset asserted in HOLD SHALL discard the pending result with no accept and no ptr update.
REQ-024 The first capture window opens on the first rising edge after reset deasserts.

Verification
REQ-025 After reset, req=4'b1010, out_ready=0 for 3 cycles -> out_valid=1, out_idx=1, out_multi=1, out_onehot=4'b0010, stable for all 3 cycles.
REQ-026 req held at 4'b1111, out_ready=1 continuously -> out_idx sequence 0,1,2,3,0,... with out_valid=1 every cycle and out_multi=1.
REQ-027 Wrap: accept out_idx=3, then req=4'b1001 -> next out_idx=0 (ptr=0), not 3.
REQ-028 req=4'b0100 single cycle then 0, out_ready=1 -> one valid cycle with out_idx=2 and out_multi=0, then out_valid=0; ptr=3.
REQ-029 HOLD with out_idx=2, assert reset mid-cycle -> out_valid=0 and ptr=0 before next edge; after release, req=4'b0100 -> out_idx=2.
REQ-030 Scoreboard over random req/out_ready SHALL match a reference model of REQ-013..REQ-017 every cycle, and no active requester SHALL wait more than 4 accepts.

Source files
------------

// File: rtl/rr_encoder_4_2.sv
// Round-robin 4:2 priority encoder with a registered, valid/ready output stage.
// Latency 1 cycle, no bubbles; while out_valid && !out_ready the result and pointer freeze and req is ignored.
module rr_encoder_4_2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [1:0] out_idx,
  output logic       out_multi,
  output logic [3:0] out_onehot
);

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic       multi_q, multi_d;
  logic [1:0] ptr_q, ptr_d;

  logic       accept;
  logic       window;
  logic [1:0] search_base;
  logic [3:0] req_rot;
  logic [1:0] rot_off;
  logic [1:0] sel_idx;
  logic       req_multi;

  assign accept      = (state_q == HOLD) && out_ready;
  assign window      = (state_q == EMPTY) || out_ready;
  assign search_base = accept ? (idx_q + 2'd1) : ptr_q;

  // Rotate so the search base lands on bit 0; the lowest set bit then wins.
  always_comb begin
    req_rot = req;
    case (search_base)
      2'd0: req_rot = req;
      2'd1: req_rot = {req[0],   req[3:1]};
      2'd2: req_rot = {req[1:0], req[3:2]};
      2'd3: req_rot = {req[2:0], req[3]};
      default: req_rot = req;
    endcase
  end

  always_comb begin
    rot_off = 2'd0;
    casez (req_rot)
      4'b???1: rot_off = 2'd0;
      4'b??10: rot_off = 2'd1;
      4'b?100: rot_off = 2'd2;
      4'b1000: rot_off = 2'd3;
      default: rot_off = 2'd0;
    endcase
  end

  assign sel_idx   = search_base + rot_off;
  assign req_multi = (req & (req - 4'd1)) != 4'd0;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    multi_d = multi_q;
    ptr_d   = ptr_q;

    if (accept) begin
      ptr_d = idx_q + 2'd1;
    end

    // An empty window drops valid but keeps the last index/multi visible.
    if (window) begin
      if (req != 4'd0) begin
        state_d = HOLD;
        idx_d   = sel_idx;
        multi_d = req_multi;
      end else begin
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      idx_q   <= 2'd0;
      multi_q <= 1'b0;
      ptr_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      multi_q <= multi_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid  = (state_q == HOLD);
  assign out_idx    = idx_q;
  assign out_multi  = multi_q;
  assign out_onehot = out_valid ? (4'b0001 << idx_q) : 4'b0000;

endmodule

// File: tb/tb_rr_encoder_4_2.sv
// Bench for rr_encoder_4_2: directed vectors plus a sticky-request random run,
// expected outputs queued at drive time and checked by an independent monitor.
module tb_rr_encoder_4_2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'd0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [1:0] out_idx;
  logic       out_multi;
  logic [3:0] out_onehot;

  rr_encoder_4_2 dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_idx    (out_idx),
    .out_multi  (out_multi),
    .out_onehot (out_onehot)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         id;
    logic       vld;
    logic [1:0] idx;
    logic       multi;
  } exp_t;

  typedef struct packed {
    logic [3:0] req;
    logic       rdy;
    logic       vld;
    logic [1:0] idx;
    logic       multi;
  } vec_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  bit   track_en = 1'b0;
  logic prev_vld = 1'b0;
  logic [1:0] prev_idx = 2'd0;
  int   waitc [4] = '{0, 0, 0, 0};

  // Hand-derived: req, out_ready, then expected valid/idx/multi after the edge.
  vec_t vecs [0:24] = '{
    '{4'b1010, 1'b0, 1'b1, 2'd1, 1'b1},
    '{4'b0100, 1'b0, 1'b1, 2'd1, 1'b1},
    '{4'b1010, 1'b0, 1'b1, 2'd1, 1'b1},
    '{4'b1111, 1'b1, 1'b1, 2'd2, 1'b1},
    '{4'b1111, 1'b1, 1'b1, 2'd3, 1'b1},
    '{4'b1111, 1'b1, 1'b1, 2'd0, 1'b1},
    '{4'b1111, 1'b1, 1'b1, 2'd1, 1'b1},
    '{4'b1111, 1'b1, 1'b1, 2'd2, 1'b1},
    '{4'b1111, 1'b1, 1'b1, 2'd3, 1'b1},
    '{4'b1001, 1'b1, 1'b1, 2'd0, 1'b1},
    '{4'b0000, 1'b1, 1'b0, 2'd0, 1'b1},
    '{4'b0100, 1'b1, 1'b1, 2'd2, 1'b0},
    '{4'b0000, 1'b1, 1'b0, 2'd2, 1'b0},
    '{4'b0000, 1'b1, 1'b0, 2'd2, 1'b0},
    '{4'b1011, 1'b0, 1'b1, 2'd3, 1'b1},
    '{4'b0000, 1'b0, 1'b1, 2'd3, 1'b1},
    '{4'b0110, 1'b1, 1'b1, 2'd1, 1'b1},
    '{4'b0001, 1'b1, 1'b1, 2'd0, 1'b0},
    '{4'b1000, 1'b1, 1'b1, 2'd3, 1'b0},
    '{4'b0100, 1'b1, 1'b1, 2'd2, 1'b0},
    '{4'b0100, 1'b1, 1'b1, 2'd2, 1'b0},
    '{4'b0000, 1'b0, 1'b1, 2'd2, 1'b0},
    '{4'b1001, 1'b0, 1'b1, 2'd0, 1'b1},
    '{4'b0000, 1'b1, 1'b0, 2'd0, 1'b1},
    '{4'b0100, 1'b0, 1'b1, 2'd2, 1'b0}
  };

  task automatic chk(input string name, input int id, input logic [31:0] got, input logic [31:0] want);
    n_assert++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s #%0d: actual %0h required %0h", name, id, got, want);
    end
  endtask

  // Monitor: one sample per cycle, 1 time unit after the rising edge.
  always @(posedge clock) begin
    int worst;
    exp_t e;
    #1;
    if (track_en && prev_vld && out_ready) begin
      worst = 0;
      for (int i = 0; i < 4; i++) begin
        if (2'(i) == prev_idx)  waitc[i] = 0;
        else if (req[i])        waitc[i] = waitc[i] + 1;
        else                    waitc[i] = 0;
        if (waitc[i] > worst) worst = waitc[i];
      end
      chk("max_wait_le4", worst, 32'(worst <= 4), 32'd1);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("out_valid",  e.id, 32'(out_valid),  32'(e.vld));
      chk("out_idx",    e.id, 32'(out_idx),    32'(e.idx));
      chk("out_multi",  e.id, 32'(out_multi),  32'(e.multi));
      chk("out_onehot", e.id, 32'(out_onehot), 32'(e.vld ? (4'b0001 << e.idx) : 4'b0000));
    end
    prev_vld = out_valid;
    prev_idx = out_idx;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    exp_t       e;
    logic       m_vld, m_multi, acc, found;
    logic [1:0] m_idx, m_ptr, old_idx, p, c;
    logic [3:0] sticky, r;
    logic       rdy;

    // Reset dominates even with live inputs.
    req       = 4'b1111;
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #2;
    chk("rst_valid",  0, 32'(out_valid),  32'd0);
    chk("rst_idx",    0, 32'(out_idx),    32'd0);
    chk("rst_multi",  0, 32'(out_multi),  32'd0);
    chk("rst_onehot", 0, 32'(out_onehot), 32'd0);
    #1 reset = 1'b0;

    for (int v = 0; v < 25; v++) begin
      @(negedge clock);
      req       = vecs[v].req;
      out_ready = vecs[v].rdy;
      e.id = v; e.vld = vecs[v].vld; e.idx = vecs[v].idx; e.multi = vecs[v].multi;
      exp_q.push_back(e);
      if (v == 21) begin
        // HOLD with idx 2 and ptr 3: asynchronous reset between edges.
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("midrst_valid",  v, 32'(out_valid),  32'd0);
        chk("midrst_idx",    v, 32'(out_idx),    32'd0);
        chk("midrst_multi",  v, 32'(out_multi),  32'd0);
        chk("midrst_onehot", v, 32'(out_onehot), 32'd0);
        #1 reset = 1'b0;
      end
    end

    // State left by the final directed vector.
    m_vld = 1'b1; m_idx = 2'd2; m_multi = 1'b0; m_ptr = 2'd1;
    sticky = 4'd0;
    acc = 1'b0;
    old_idx = 2'd0;
    track_en = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clock);
      if (acc) sticky = sticky & ~(4'b0001 << old_idx);
      sticky = sticky | (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
      r   = sticky;
      rdy = ($urandom_range(0, 3) != 0);
      req       = r;
      out_ready = rdy;

      old_idx = m_idx;
      acc     = m_vld && rdy;
      p       = acc ? old_idx + 2'd1 : m_ptr;
      if (!m_vld || rdy) begin
        if (r != 4'd0) begin
          found = 1'b0;
          for (int k = 0; k < 4; k++) begin
            c = p + 2'(k);
            if (!found && r[c]) begin
              found = 1'b1;
              m_idx = c;
            end
          end
          m_multi = ($countones(r) > 1);
          m_vld   = 1'b1;
        end else begin
          m_vld = 1'b0;
        end
      end
      if (acc) m_ptr = old_idx + 2'd1;
      e.id = 100 + n; e.vld = m_vld; e.idx = m_idx; e.multi = m_multi;
      exp_q.push_back(e);
    end

    repeat (3) @(negedge clock);
    track_en = 1'b0;
    chk("queue_drained", 0, 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
